// File: rtl/if_fetch_unit.sv
// IF-stage fetch engine: owns the PC, issues req/ready fetches and buffers up to 2 words for IF/ID.
// Latency: an accepted word reaches instruction_o the next cycle; stall_i holds the head entry.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] PC_o,
  output logic [31:0] instruction_o,
  output logic        fetch_valid_o,
  output logic        IFID_flush_o
);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [31:0] fifo_pc_q    [2];
  logic [31:0] fifo_instr_q [2];
  logic        rd_ptr_q, wr_ptr_q;
  logic [1:0]  count_q, count_d;
  logic        accept, push, pop;
  logic [31:0] target;

  assign target     = branch_target_i & ~32'h3;
  assign imem_req_o = (state_q == REQ) || (state_q == DROP);
  assign accept     = imem_req_o && imem_ready_i;
  assign pop        = !stall_i && (count_q != 2'd0) && !branch_i;
  assign push       = accept && (state_q == REQ) && !branch_i;

  always_comb begin
    if (branch_i) count_d = 2'd0;
    else          count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      IDLE: begin
        if (branch_i) begin
          fetch_pc_d = target;
          state_d    = REQ;
        end else if (count_d < 2'd2) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (accept) begin
          if (branch_i) begin
            fetch_pc_d = target;
            state_d    = REQ;
          end else begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = (count_d < 2'd2) ? REQ : IDLE;
          end
        end else if (branch_i) begin
          // address must stay stable until the in-flight request is taken
          redirect_pc_d = target;
          state_d       = DROP;
        end
      end
      DROP: begin
        if (branch_i) redirect_pc_d = target;
        if (accept) begin
          fetch_pc_d = branch_i ? target : redirect_pc_q;
          state_d    = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_PC;
      redirect_pc_q <= 32'h0;
      count_q       <= 2'd0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      redirect_pc_q <= redirect_pc_d;
      count_q       <= count_d;
      if (branch_i) begin
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
      end else begin
        if (push) wr_ptr_q <= ~wr_ptr_q;
        if (pop)  rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  // payload storage needs no reset: it is only visible while count_q != 0
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]    <= fetch_pc_q;
      fifo_instr_q[wr_ptr_q] <= imem_rdata_i;
    end
  end

  assign imem_addr_o   = fetch_pc_q;
  assign fetch_valid_o = (count_q != 2'd0);
  assign PC_o          = fetch_valid_o ? fifo_pc_q[rd_ptr_q]    : 32'h0;
  assign instruction_o = fetch_valid_o ? fifo_instr_q[rd_ptr_q] : 32'h0;
  assign IFID_flush_o  = branch_i;

  a_count_max: assert property (@(posedge clk_i) disable iff (!rst_i) count_q <= 2'd2);
  a_req_room:  assert property (@(posedge clk_i) disable iff (!rst_i)
                                (state_q == REQ) |-> (count_q <= 2'd1));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: queue-based reference model checked every cycle, directed scenarios
// with literal pins, then randomized stall/branch/ready traffic.
module tb_if_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0, branch = 1'b0, ready = 1'b0;
  logic [31:0] target = 32'h0, imem_rdata = 32'h0;
  logic        imem_req_o, fetch_valid_o, IFID_flush_o;
  logic [31:0] imem_addr_o, PC_o, instruction_o;

  if_fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .branch_i(branch),
    .branch_target_i(target), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ready_i(ready), .imem_rdata_i(imem_rdata), .PC_o(PC_o),
    .instruction_o(instruction_o), .fetch_valid_o(fetch_valid_o), .IFID_flush_o(IFID_flush_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
  ent_t        q[$];
  bit          m_req, m_drop, rnd;
  logic [31:0] m_pc, m_redir;
  int          n_cmp = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_req = 0; m_drop = 0; m_pc = 32'h0; m_redir = 32'h0;
  endtask

  // one clock edge of the fetch engine described as a queue plus an outstanding-request flag
  task automatic model_step();
    bit acc;
    logic [31:0] tgt;
    acc = m_req && ready;
    tgt = {target[31:2], 2'b00};
    if (branch) begin
      q.delete();
      if (m_drop) begin
        m_redir = tgt;
        if (acc) begin m_pc = tgt; m_drop = 0; end
      end else if (m_req && !acc) begin
        m_drop = 1; m_redir = tgt;
      end else begin
        m_pc = tgt;
      end
      m_req = 1;
    end else begin
      if (!stall && q.size() != 0) void'(q.pop_front());
      if (m_drop) begin
        if (acc) begin m_pc = m_redir; m_drop = 0; end
        m_req = 1;
      end else if (m_req && !acc) begin
        m_req = 1;
      end else begin
        if (acc) begin
          q.push_back('{m_pc, imem_rdata});
          m_pc = m_pc + 32'd4;
        end
        m_req = (q.size() < 2);
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    chk("req",   32'(imem_req_o),    32'(m_req));
    chk("addr",  imem_addr_o,        m_pc);
    chk("valid", 32'(fetch_valid_o), 32'(q.size() != 0));
    chk("flush", 32'(IFID_flush_o),  32'(branch));
    chk("pc",    PC_o,               (q.size() != 0) ? q[0].pc  : 32'h0);
    chk("instr", instruction_o,      (q.size() != 0) ? q[0].ins : 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    imem_rdata = rnd ? $urandom : (m_pc | 32'h13);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin sample(); tick(); end
  endtask

  initial begin
    rnd = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req",   32'(imem_req_o),    32'h0);
    chk("rst_addr",  imem_addr_o,        32'h0);
    chk("rst_pc",    PC_o,               32'h0);
    chk("rst_instr", instruction_o,      32'h0);
    chk("rst_valid", 32'(fetch_valid_o), 32'h0);
    chk("rst_flush", 32'(IFID_flush_o),  32'h0);
    rst = 1; ready = 1; imem_rdata = 32'h13;

    // streaming, then a 4-cycle stall with a full queue
    run(2);
    sample(); chk("t1_pc", PC_o, 32'h0); chk("t1_ins", instruction_o, 32'h13);
    chk("t1_valid", 32'(fetch_valid_o), 32'h1); tick(); stall = 1;
    sample(); chk("t1_pc4", PC_o, 32'h4); chk("t1_ins4", instruction_o, 32'h17); tick();
    sample(); chk("t2_req", 32'(imem_req_o), 32'h0); chk("t2_hold", PC_o, 32'h4);
    chk("t2_addr", imem_addr_o, 32'hC); tick();
    run(2); stall = 0;
    run(1);
    sample(); chk("t2_pc8", PC_o, 32'h8); chk("t2_addrc", imem_addr_o, 32'hC); tick();
    sample(); chk("t2_pcc", PC_o, 32'hC); chk("t2_insc", instruction_o, 32'h1F); tick();
    ready = 0;

    // memory not ready: address held, queue drains to a bubble
    run(1);
    sample(); chk("t3_valid", 32'(fetch_valid_o), 32'h0); chk("t3_ins", instruction_o, 32'h0);
    chk("t3_addr", imem_addr_o, 32'h14); tick();
    sample(); chk("t3_addr2", imem_addr_o, 32'h14); tick();
    branch = 1; target = 32'h100;

    // redirect while a request is outstanding
    sample(); chk("t4_flush", 32'(IFID_flush_o), 32'h1); tick(); branch = 0;
    sample(); chk("t4_hold", imem_addr_o, 32'h14); chk("t4_req", 32'(imem_req_o), 32'h1);
    tick(); ready = 1;
    run(1);
    sample(); chk("t4_addr", imem_addr_o, 32'h100); chk("t4_valid", 32'(fetch_valid_o), 32'h0);
    tick();
    sample(); chk("t4_pc", PC_o, 32'h100); chk("t4_ins", instruction_o, 32'h113); tick();
    stall = 1;

    // redirect with a full, stalled queue (target low bits ignored)
    run(1);
    branch = 1; target = 32'h202;
    sample(); chk("t5_req", 32'(imem_req_o), 32'h0); chk("t5_pc", PC_o, 32'h104); tick();
    branch = 0; stall = 0;
    sample(); chk("t5_valid", 32'(fetch_valid_o), 32'h0); chk("t5_addr", imem_addr_o, 32'h200);
    tick(); branch = 1; target = 32'h40;
    run(1); branch = 0; ready = 0;

    // asynchronous reset in the middle of a pending request
    sample(); chk("t6_addr", imem_addr_o, 32'h40);
    #2 rst = 0; model_reset();
    #1;
    chk("t6_req", 32'(imem_req_o), 32'h0); chk("t6_valid", 32'(fetch_valid_o), 32'h0);
    chk("t6_addr0", imem_addr_o, 32'h0);
    @(posedge clk); #1;
    rst = 1; ready = 1; imem_rdata = 32'h13;
    run(1);
    sample(); chk("t6_restart", imem_addr_o, 32'h0); chk("t6_req1", 32'(imem_req_o), 32'h1);
    tick(); branch = 1; target = 32'hFFFF_FFFF;

    // PC wrap-around
    run(1); branch = 0;
    sample(); chk("wrap_addr", imem_addr_o, 32'hFFFF_FFFC); tick();
    sample(); chk("wrap_addr0", imem_addr_o, 32'h0); chk("wrap_pc", PC_o, 32'hFFFF_FFFC);
    chk("wrap_ins", instruction_o, 32'hFFFF_FFFF); tick();

    // randomized traffic
    rnd = 1;
    for (int i = 0; i < 1500; i++) begin
      stall  = ($urandom_range(3) == 0);
      ready  = ($urandom_range(3) != 0);
      branch = ($urandom_range(9) == 0);
      target = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      sample();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
